// File: rtl/therm_pkg.sv
// Shared definitions for the TMP125 thermometer SPI responder.
package therm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int FRAME_BITS_DEF = 16;
  localparam int TEMP_BITS_DEF  = 10;

  // Low byte of a configuration word that enters / leaves shutdown.
  localparam logic [7:0] SHUTDOWN_CODE = 8'hFF;
  localparam logic [7:0] WAKE_CODE     = 8'h00;

  // Read frame layout: lead zero, temperature field, zero pad.
  localparam int LEAD_BIT = 15;
  localparam int TEMP_MSB = 14;
  localparam int TEMP_LSB = 5;
  localparam int PAD_MSB  = 4;
  localparam int PAD_LSB  = 0;

endpackage

// File: rtl/therm_spi_responder_sync.sv
// Multi-flop synchronizer followed by an edge-detect flop.
// SYNC_STAGES must be 2 or more.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw input through the synchronizer chain and keep one
  // extra delayed copy of the synchronized level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/therm_spi_responder.sv
// TMP125 thermometer emulation on an SPI chip-select: serves a temperature
// frame on SO, then accepts an optional configuration frame on SI that
// controls shutdown. All SPI decisions use synchronized copies of the pins.
module therm_spi_responder
  import therm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int TEMP_BITS   = TEMP_BITS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_spi_clk,
  input  logic                  i_spi_cs_n,
  input  logic                  i_spi_si,
  output logic                  o_spi_so,
  output logic                  o_spi_so_oe,
  input  logic [TEMP_BITS-1:0]  i_temperature,
  input  logic                  i_temp_valid,
  output logic                  o_shutdown,
  output logic [FRAME_BITS-1:0] o_cfg_word,
  output logic                  o_cfg_valid,
  output logic                  o_frame_done,
  output logic                  o_abort
);

  localparam int              CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_lvl_unused, cs_rise, cs_fall;
  logic si_lvl, si_rise_unused, si_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(i_clk), .rst(i_reset), .d(i_spi_clk),
    .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(i_clk), .rst(i_reset), .d(i_spi_cs_n),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_si (
    .clk(i_clk), .rst(i_reset), .d(i_spi_si),
    .level(si_lvl), .rise(si_rise_unused), .fall(si_fall_unused)
  );

  state_t                state_q, state_nxt;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_nxt;
  logic [CNT_W-1:0]      cfg_cnt_q, cfg_cnt_nxt;
  logic [FRAME_BITS-1:0] shift_q, shift_nxt;
  logic [FRAME_BITS-1:0] cfg_shift_q, cfg_shift_nxt;
  logic [FRAME_BITS-1:0] cfg_word_q, cfg_word_nxt;
  logic [TEMP_BITS-1:0]  temp_hold_q, temp_hold_nxt;
  logic                  shutdown_q, shutdown_nxt;
  logic                  frame_done_q, frame_done_nxt;
  logic                  abort_q, abort_nxt;
  logic                  cfg_valid_q, cfg_valid_nxt;
  logic [FRAME_BITS-1:0] frame_load;

  // Read frame image: lead zero, temperature just below it, zero pad.
  always_comb begin
    frame_load = '0;
    frame_load[FRAME_BITS-2 -: TEMP_BITS] = temp_hold_q;
  end

  // Next-state and next-output logic; a CS rise overrides any SPI edge.
  always_comb begin
    state_nxt      = state_q;
    bit_cnt_nxt    = bit_cnt_q;
    cfg_cnt_nxt    = cfg_cnt_q;
    shift_nxt      = shift_q;
    cfg_shift_nxt  = cfg_shift_q;
    cfg_word_nxt   = cfg_word_q;
    shutdown_nxt   = shutdown_q;
    frame_done_nxt = 1'b0;
    abort_nxt      = 1'b0;
    cfg_valid_nxt  = 1'b0;
    // Temperature is frozen while in shutdown.
    temp_hold_nxt  = (i_temp_valid && !shutdown_q) ? i_temperature : temp_hold_q;

    if (cs_rise) begin
      state_nxt = IDLE;
      abort_nxt = (state_q == READ) || ((state_q == WRITE) && (cfg_cnt_q != '0));
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            shift_nxt   = frame_load;
            bit_cnt_nxt = '0;
            cfg_cnt_nxt = '0;
            state_nxt   = READ;
          end
        end
        READ: begin
          if (sck_rise) begin
            bit_cnt_nxt = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_nxt == CNT_LAST) begin
              frame_done_nxt = 1'b1;
              state_nxt      = WRITE;
            end
          end else if (sck_fall) begin
            shift_nxt = {shift_q[FRAME_BITS-2:0], 1'b0};
          end
        end
        WRITE: begin
          if (sck_rise) begin
            cfg_shift_nxt = {cfg_shift_q[FRAME_BITS-2:0], si_lvl};
            cfg_cnt_nxt   = cfg_cnt_q + CNT_W'(1);
            if (cfg_cnt_nxt == CNT_LAST) begin
              cfg_word_nxt  = cfg_shift_nxt;
              cfg_valid_nxt = 1'b1;
              if (cfg_shift_nxt[7:0] == SHUTDOWN_CODE)
                shutdown_nxt = 1'b1;
              else if (cfg_shift_nxt[7:0] == WAKE_CODE)
                shutdown_nxt = 1'b0;
              state_nxt = HOLD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers; reset clears every register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      cfg_cnt_q    <= '0;
      shift_q      <= '0;
      cfg_shift_q  <= '0;
      cfg_word_q   <= '0;
      temp_hold_q  <= '0;
      shutdown_q   <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      cfg_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      bit_cnt_q    <= bit_cnt_nxt;
      cfg_cnt_q    <= cfg_cnt_nxt;
      shift_q      <= shift_nxt;
      cfg_shift_q  <= cfg_shift_nxt;
      cfg_word_q   <= cfg_word_nxt;
      temp_hold_q  <= temp_hold_nxt;
      shutdown_q   <= shutdown_nxt;
      frame_done_q <= frame_done_nxt;
      abort_q      <= abort_nxt;
      cfg_valid_q  <= cfg_valid_nxt;
    end
  end

  // SO is only driven with frame data during READ; the line is owned
  // whenever the responder is selected, and released as soon as reset hits.
  assign o_spi_so_oe  = (state_q != IDLE);
  assign o_spi_so     = (state_q == READ) & shift_q[FRAME_BITS-1];
  assign o_shutdown   = shutdown_q;
  assign o_cfg_word   = cfg_word_q;
  assign o_cfg_valid  = cfg_valid_q;
  assign o_frame_done = frame_done_q;
  assign o_abort      = abort_q;

endmodule

// File: tb/tb_therm_spi_responder.sv
// Directed and randomized bench for the TMP125 SPI responder, acting as
// the SPI master and modelling the thermometer's temperature/shutdown rules.
module tb_therm_spi_responder;

  localparam int SYNC = 2;
  localparam int HP   = 8;   // i_clk cycles per SPI half period

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_spi_clk = 1'b0;
  logic        i_spi_cs_n = 1'b1;
  logic        i_spi_si = 1'b0;
  logic        o_spi_so, o_spi_so_oe;
  logic [9:0]  i_temperature = '0;
  logic        i_temp_valid = 1'b0;
  logic        o_shutdown;
  logic [15:0] o_cfg_word;
  logic        o_cfg_valid, o_frame_done, o_abort;

  therm_spi_responder #(.SYNC_STAGES(SYNC), .FRAME_BITS(16), .TEMP_BITS(10)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_spi_clk(i_spi_clk), .i_spi_cs_n(i_spi_cs_n), .i_spi_si(i_spi_si),
    .o_spi_so(o_spi_so), .o_spi_so_oe(o_spi_so_oe),
    .i_temperature(i_temperature), .i_temp_valid(i_temp_valid),
    .o_shutdown(o_shutdown), .o_cfg_word(o_cfg_word), .o_cfg_valid(o_cfg_valid),
    .o_frame_done(o_frame_done), .o_abort(o_abort)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_fd = 0, n_ab = 0, n_cv = 0;

  // Reference model state
  logic [9:0]  m_temp = '0;
  logic        m_shut = 1'b0;
  logic [15:0] m_cfg  = '0;

  // Pulse counters for the one-cycle strobes
  always @(posedge i_clk) begin
    if (o_frame_done === 1'b1) n_fd <= n_fd + 1;
    if (o_abort === 1'b1)      n_ab <= n_ab + 1;
    if (o_cfg_valid === 1'b1)  n_cv <= n_cv + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_frame(input logic [9:0] t);
    return 16'(t) * 16'd32;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic load_temp(input logic [9:0] t);
    @(negedge i_clk);
    i_temperature = t;
    i_temp_valid  = 1'b1;
    @(negedge i_clk);
    i_temp_valid  = 1'b0;
    if (!m_shut) m_temp = t;
  endtask

  // One SPI mode-0 bit: master drives SI while SCK is low, samples SO at the rise.
  task automatic spi_bit(input logic si_b, output logic so_b);
    i_spi_si = si_b;
    wait_clk(HP);
    so_b = o_spi_so;
    i_spi_clk = 1'b1;
    wait_clk(HP);
    i_spi_clk = 1'b0;
  endtask

  // Frame body with CS already low: 16 read bits, optional 16 write bits, CS up.
  task automatic body(input logic do_wr, input logic [15:0] wr, output logic [15:0] rd);
    logic b;
    for (int i = 15; i >= 0; i--) begin
      spi_bit(1'b0, b);
      rd[i] = b;
    end
    if (do_wr)
      for (int i = 15; i >= 0; i--) spi_bit(wr[i], b);
    wait_clk(HP);
    i_spi_cs_n = 1'b1;
    i_spi_si   = 1'b0;
    wait_clk(HP);
  endtask

  task automatic xact(input string tag, input logic do_wr, input logic [15:0] wr,
                      input logic [15:0] exp_rd);
    int fd0, ab0, cv0;
    logic [15:0] rd;
    fd0 = n_fd; ab0 = n_ab; cv0 = n_cv;
    i_spi_cs_n = 1'b0;
    wait_clk(HP);
    check({tag, "_oe_selected"}, o_spi_so_oe, 1);
    body(do_wr, wr, rd);
    check({tag, "_data"}, rd, exp_rd);
    check({tag, "_frame_done_pulses"}, n_fd - fd0, 1);
    check({tag, "_abort_pulses"}, n_ab - ab0, 0);
    check({tag, "_oe_released"}, o_spi_so_oe, 0);
    if (do_wr) begin
      m_cfg = wr;
      if (wr[7:0] == 8'hFF) m_shut = 1'b1;
      else if (wr[7:0] == 8'h00) m_shut = 1'b0;
      check({tag, "_cfg_valid_pulses"}, n_cv - cv0, 1);
    end else begin
      check({tag, "_cfg_valid_pulses"}, n_cv - cv0, 0);
    end
    check({tag, "_cfg_word"}, o_cfg_word, m_cfg);
    check({tag, "_shutdown"}, o_shutdown, m_shut);
  endtask

  initial begin
    logic        b;
    logic [15:0] rd, ef, wr;
    logic [9:0]  t;
    int          ab0, fd0, sel;
    logic        do_wr;

    // Reset state
    wait_clk(4);
    check("rst_oe", o_spi_so_oe, 0);
    check("rst_so", o_spi_so, 0);
    check("rst_shutdown", o_shutdown, 0);
    check("rst_cfg_word", o_cfg_word, 0);
    check("rst_strobes", {o_cfg_valid, o_frame_done, o_abort}, 0);
    i_reset = 1'b0;
    wait_clk(4);

    // Temperature reads, positive and negative
    load_temp(10'h0C8);
    xact("read_50C", 1'b0, 16'h0000, 16'h1900);
    load_temp(10'h3D8);
    xact("read_neg10C", 1'b0, 16'h0000, 16'h7B00);

    // Shutdown freezes the temperature, wake releases it
    load_temp(10'h0C8);
    xact("wr_shutdown", 1'b1, 16'h00FF, 16'h1900);
    check("shutdown_set", o_shutdown, 1);
    load_temp(10'h064);
    xact("read_frozen", 1'b0, 16'h0000, 16'h1900);
    xact("wr_wake", 1'b1, 16'h0000, 16'h1900);
    check("shutdown_clear", o_shutdown, 0);
    load_temp(10'h064);
    xact("read_woken", 1'b0, 16'h0000, 16'h0C80);

    // Mid-frame disconnect after 7 SPI clocks
    ab0 = n_ab; fd0 = n_fd;
    i_spi_cs_n = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < 7; i++) spi_bit(1'b0, b);
    wait_clk(2);
    i_spi_cs_n = 1'b1;
    repeat (SYNC + 2) @(posedge i_clk);
    #1;
    check("abort_oe_drop", o_spi_so_oe, 0);
    wait_clk(HP);
    check("abort_pulses", n_ab - ab0, 1);
    check("abort_no_frame_done", n_fd - fd0, 0);
    xact("read_after_abort", 1'b0, 16'h0000, 16'h0C80);

    // Temperature strobe coincident with the CS-fall snapshot
    load_temp(10'h0C8);
    @(negedge i_clk);
    i_spi_cs_n = 1'b0;
    repeat (SYNC) @(posedge i_clk);
    @(negedge i_clk);
    i_temperature = 10'h001;
    i_temp_valid  = 1'b1;
    @(negedge i_clk);
    i_temp_valid  = 1'b0;
    wait_clk(HP);
    body(1'b0, 16'h0000, rd);
    check("race_snapshot_old", rd, 16'h1900);
    m_temp = 10'h001;
    xact("race_next_frame", 1'b0, 16'h0000, 16'h0020);

    // Randomized reads and configuration writes against the model
    for (int k = 0; k < 8; k++) begin
      t = 10'($urandom_range(0, 1023));
      load_temp(t);
      sel = $urandom_range(0, 2);
      wr  = 16'($urandom);
      if (sel == 0) wr[7:0] = 8'hFF;
      else if (sel == 1) wr[7:0] = 8'h00;
      do_wr = 1'($urandom_range(0, 1));
      xact("rand", do_wr, wr, exp_frame(m_temp));
    end

    // Async reset mid-READ
    xact("pre_reset_wake", 1'b1, 16'h1200, exp_frame(m_temp));
    load_temp(10'h3FF);
    ab0 = n_ab;
    i_spi_cs_n = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, b);
    wait_clk(4);
    ef = exp_frame(m_temp);
    check("so_before_reset", o_spi_so, ef[10]);
    check("oe_before_reset", o_spi_so_oe, 1);
    #2;
    i_reset = 1'b1;
    #1;
    check("areset_oe", o_spi_so_oe, 0);
    check("areset_so", o_spi_so, 0);
    check("areset_cfg_word", o_cfg_word, 0);
    check("areset_strobes", {o_cfg_valid, o_frame_done, o_abort}, 0);
    i_spi_cs_n = 1'b1;
    wait_clk(4);
    i_reset = 1'b0;
    m_temp = '0; m_shut = 1'b0; m_cfg = '0;
    wait_clk(HP);
    check("areset_no_abort", n_ab - ab0, 0);
    check("areset_shutdown", o_shutdown, 0);
    xact("read_after_reset", 1'b0, 16'h0000, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/therm_spi_responder.md
Name: therm_spi_responder

Overview:
Synthesizable SPI responder that emulates the TMP125 thermometer at the slave end of the SPI handler's thermometer chip-select. It serves a 16-bit temperature frame on SO, then accepts an optional 16-bit configuration frame on SI that controls shutdown. It is used for FPGA-in-loop testing and as a reusable slave for the shared SO line, alongside the flash responder.

Parameters:
SYNC_STAGES, 2, synchronizer depth for i_spi_clk, i_spi_cs_n and i_spi_si
FRAME_BITS, 16, bits per read frame and per write frame
TEMP_BITS, 10, width of the temperature field, two's complement, 0.25 C/LSB

Ports:
i_clk  in  1  system clock; must run at 8x the SPI clock or faster
i_reset  in  1  asynchronous, active-high reset
i_spi_clk  in  1  SPI clock from master, mode 0, idles low
i_spi_cs_n  in  1  chip select, active low
i_spi_si  in  1  master-out data
o_spi_so  out  1  slave-out data
o_spi_so_oe  out  1  SO output enable; shared line, high only while selected
i_temperature  in  TEMP_BITS  new temperature sample
i_temp_valid  in  1  one-cycle strobe that qualifies i_temperature
o_shutdown  out  1  shutdown mode active
o_cfg_word  out  16  last complete configuration word written
o_cfg_valid  out  1  one-cycle pulse when o_cfg_word updates
o_frame_done  out  1  one-cycle pulse when the 16th read bit completes
o_abort  out  1  one-cycle pulse when CS rises mid-frame

Behaviour:
- Reset values:
  - All outputs are 0.
  - temp_hold = 0.
  - State = IDLE.
  - Synchronizers reset to cs_n=1, spi_clk=0, si=0.
- Synchronization: each SPI input passes through SYNC_STAGES flops, then a flop for edge detection. All decisions use the synchronized signals only.
- temp_hold update:
  - On i_temp_valid with o_shutdown=0: temp_hold <= i_temperature.
  - While o_shutdown=1: i_temp_valid is ignored.
- State IDLE:
  - o_spi_so_oe=0, o_spi_so=0.
  - On CS falling edge: shift_reg <= {1'b0, temp_hold, 5'b0}, bit counter = 0, oe=1, SO = shift_reg MSB. Go to READ.
- State READ:
  - On SPI rising edge: counter increments.
  - On SPI falling edge: shift left and present the next MSB.
  - When the counter reaches FRAME_BITS on a rising edge: pulse o_frame_done, drive SO=0, go to WRITE.
- State WRITE:
  - On SPI rising edge: capture SI into cfg_shift, MSB-first.
  - After 16 bits:
    - o_cfg_word <= cfg_shift and pulse o_cfg_valid.
    - If cfg[7:0]==8'hFF, set o_shutdown. If cfg[7:0]==8'h00, clear o_shutdown. Otherwise o_shutdown is unchanged.
    - Go to HOLD.
- State HOLD: SO=0, oe=1, further SPI edges are ignored.
- CS rising edge, from any state:
  - Go to IDLE; oe=0 on the next cycle.
  - Pulse o_abort if in READ with counter<16, or in WRITE with a partial count (1..15).
  - WRITE with 0 bits captured, or HOLD, is a normal end with no abort.
- Latency: SO changes within SYNC_STAGES+2 i_clk cycles of the SPI falling edge (or of the CS falling edge, for the first bit).
- Simultaneous events:
  - A CS rising edge on the same cycle as an SPI edge: CS wins, and the SPI edge is ignored.
  - i_temp_valid on the same cycle as the CS-fall snapshot: the snapshot takes the old temp_hold.
  - A completed config write that sets shutdown freezes temp_hold from the next cycle.
- Async reset mid-frame: oe drops immediately and all registers take their reset values. There is no abort pulse.

Decomposition:
- Package therm_pkg:
  - State encoding: IDLE, READ, WRITE, HOLD.
  - FRAME_BITS default.
  - SHUTDOWN_CODE=8'hFF and WAKE_CODE=8'h00.
  - Frame field positions: lead bit 15, temperature 14:5, pad 4:0.
- Sub-module spi_sync_edge: parameterized synchronizer plus rise/fall detect. Instanced three times, for spi_clk, cs_n and si (si uses the level only).

Test Plan:
- Temperature read: reset; i_temp_valid with 10'h0C8 (50 C); CS low; 16 SPI clocks -> master samples 0x1900 on rising edges; one o_frame_done pulse; oe=0 after CS rises.
- Negative temperature: load 10'h3D8 (-10 C), read -> 0x7B00; no o_abort pulse.
- Shutdown: read, then write 0x00FF in the same CS window -> o_cfg_valid pulse, o_cfg_word=0x00FF, o_shutdown=1; load 10'h064; next read still returns 0x1900. Write 0x0000 -> o_shutdown=0; load 10'h064; next read returns 0x0C80.
- Mid-frame disconnect: CS rises after 7 SPI clocks -> one o_abort pulse; oe=0 within SYNC_STAGES+2 cycles; the following full read returns the correct value.
- Race: i_temp_valid (10'h001) on the exact cycle of the CS-fall snapshot, with prior 10'h0C8 -> frame reads 0x1900; the next frame reads 0x0020.
- Async reset asserted mid-READ -> o_spi_so_oe and o_spi_so go 0 immediately; all outputs hold reset values; no o_abort pulse.
